uart_rx_frame_timer: RTL and testbench

Parametrised edge/bit timing engine for the UART receive path. It counts oversampling edges within each bit and bits within a frame, and generates three mid-bit sample strobes for majority voting. It also emits bit-done and frame-done pulses. The frame format is configurable: data width by parameter; parity and 1/2 stop bits at runtime. It sits between the RX FSM, which drives the enable, and the data/parity/stop sampler and checkers.

---
 rtl/uart_rx_frame_timer.sv | 103 ++++++++++
 tb/tb_uart_rx_frame_timer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_timer.sv
// Edge/bit timing engine for the UART receive path: edge and bit counters,
// three mid-bit sample strobes, and bit/frame completion pulses.
module uart_rx_frame_timer #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6,
  localparam int BIT_W  = $clog2(DATA_W + 5)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cnt_en,
  input  logic               PAR_EN,
  input  logic               STOP2,
  input  logic [PRESC_W-1:0] prescale,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sample_stb,
  output logic               sample_last,
  output logic               bit_done,
  output logic               frame_done,
  output logic               cfg_err
);

  localparam logic [PRESC_W-1:0] PRESC_RST = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] PRESC_MIN = PRESC_W'(4);
  localparam logic [PRESC_W-1:0] P_ONE     = PRESC_W'(1);
  localparam logic [BIT_W-1:0]   LAST_BASE = BIT_W'(DATA_W + 1);
  localparam logic [BIT_W-1:0]   B_ONE     = BIT_W'(1);

  // Shadow configuration, frozen while a frame is being timed
  logic [PRESC_W-1:0] r_presc_s;
  logic               r_par_s;
  logic               r_stop2_s;

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;

  logic               w_cfg_err;
  logic               w_run;
  logic [PRESC_W-1:0] w_mid;
  logic [PRESC_W-1:0] w_edge_max;
  logic [BIT_W-1:0]   w_last_bit;
  logic               w_edge_last;
  logic               w_bit_last;
  logic               w_in_window;
  logic [PRESC_W-1:0] w_edge_nxt;
  logic [BIT_W-1:0]   w_bit_nxt;

  assign w_cfg_err  = (r_presc_s < PRESC_MIN);
  assign w_run      = cnt_en & ~w_cfg_err;
  assign w_mid      = r_presc_s >> 1;
  assign w_edge_max = r_presc_s - P_ONE;
  // Index of the final stop bit: start + data + optional parity + 1 or 2 stops
  assign w_last_bit = LAST_BASE
                    + {{(BIT_W-1){1'b0}}, r_par_s}
                    + {{(BIT_W-1){1'b0}}, r_stop2_s};

  assign w_edge_last = (r_edge_cnt == w_edge_max);
  assign w_bit_last  = (r_bit_cnt == w_last_bit);
  assign w_in_window = (r_edge_cnt == (w_mid - P_ONE))
                     | (r_edge_cnt == w_mid)
                     | (r_edge_cnt == (w_mid + P_ONE));

  always_comb begin
    w_edge_nxt = '0;
    w_bit_nxt  = '0;
    if (w_run) begin
      if (w_edge_last) begin
        w_edge_nxt = '0;
        w_bit_nxt  = w_bit_last ? '0 : (r_bit_cnt + B_ONE);
      end else begin
        w_edge_nxt = r_edge_cnt + P_ONE;
        w_bit_nxt  = r_bit_cnt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_presc_s  <= PRESC_RST;
      r_par_s    <= 1'b0;
      r_stop2_s  <= 1'b0;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (!cnt_en) begin
        r_presc_s <= prescale;
        r_par_s   <= PAR_EN;
        r_stop2_s <= STOP2;
      end
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
    end
  end

  assign edge_cnt    = r_edge_cnt;
  assign bit_cnt     = r_bit_cnt;
  assign cfg_err     = w_cfg_err;
  assign sample_stb  = w_run & w_in_window;
  assign sample_last = w_run & (r_edge_cnt == (w_mid + P_ONE));
  assign bit_done    = w_run & w_edge_last;
  assign frame_done  = w_run & w_edge_last & w_bit_last;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed bench for uart_rx_frame_timer: frame timing for several formats,
// config shadowing, idle clear, config error and reset behaviour.
module tb_uart_rx_frame_timer;

  logic       CLK;
  logic       RST;
  logic       cnt_en;
  logic       PAR_EN;
  logic       STOP2;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic       sample_last;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_on   = 1'b0;
  logic [15:0] exp_q[$];

  uart_rx_frame_timer #(.DATA_W(8), .PRESC_W(6)) dut (
    .CLK(CLK), .RST(RST), .cnt_en(cnt_en), .PAR_EN(PAR_EN), .STOP2(STOP2),
    .prescale(prescale), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .sample_stb(sample_stb), .sample_last(sample_last), .bit_done(bit_done),
    .frame_done(frame_done), .cfg_err(cfg_err)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s k=%0d obs=%0h exp=%0h", tag, k, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input int k, input int e, input int b,
                           input bit stb, input bit lst, input bit bd, input bit fd, input bit err);
    chk({tag, ".edge"}, k, 32'(edge_cnt), e);
    chk({tag, ".bit"},  k, 32'(bit_cnt), b);
    chk({tag, ".stb"},  k, 32'(sample_stb), 32'(stb));
    chk({tag, ".last"}, k, 32'(sample_last), 32'(lst));
    chk({tag, ".bd"},   k, 32'(bit_done), 32'(bd));
    chk({tag, ".fd"},   k, 32'(frame_done), 32'(fd));
    chk({tag, ".err"},  k, 32'(cfg_err), 32'(err));
  endtask

  // Expected timing for an active frame with p edges/bit, bits 0..last
  task automatic run(input string tag, input int n, input int p, input int mid, input int last, input int k0);
    int e;
    int b;
    bit fd;
    for (int k = k0; k < k0 + n; k++) begin
      e  = k % p;
      b  = (k / p) % (last + 1);
      fd = (e == p - 1) && (b == last);
      check_all(tag, k, e, b, (e >= mid - 1) && (e <= mid + 1), e == mid + 1, e == p - 1, fd, 1'b0);
      if (sb_on && frame_done === 1'b1) begin
        if (exp_q.size() > 0) chk({tag, ".sb_k"}, k, k, 32'(exp_q.pop_front()));
        else chk({tag, ".sb_extra"}, k, 1, 0);
      end
      tick();
    end
  endtask

  task automatic go_idle(input int p, input bit par, input bit st2);
    cnt_en   = 1'b0;
    prescale = 6'(p);
    PAR_EN   = par;
    STOP2    = st2;
    tick();
  endtask

  task automatic start();
    cnt_en = 1'b1;
    #1;
  endtask

  initial begin
    RST = 1'b0; cnt_en = 1'b0; PAR_EN = 1'b0; STOP2 = 1'b0; prescale = 6'd5;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Enable in the first cycle out of reset: reset shadow (8 edges) applies
    RST = 1'b1; cnt_en = 1'b1; #1;
    run("rst_shadow", 16, 8, 4, 9, 0);

    // 8 data, prescale 8, no parity, one stop: 80-cycle frame
    go_idle(8, 0, 0);
    start();
    run("f8n1", 80, 8, 4, 9, 0);
    cnt_en = 1'b0; #1;
    check_all("f8n1_off", 80, 0, 0, 0, 0, 0, 0, 0);

    // prescale 16, parity, two stops: 12 bits, two back-to-back frames
    go_idle(16, 1, 1);
    exp_q.push_back(16'd191);
    exp_q.push_back(16'd383);
    sb_on = 1'b1;
    start();
    run("f16p2", 384, 16, 8, 11, 0);
    sb_on = 1'b0;
    chk("f16p2.sb_left", 0, exp_q.size(), 0);

    // Odd prescale rounds mid down
    go_idle(5, 0, 0);
    start();
    run("p5", 50, 5, 2, 9, 0);

    // Smallest legal prescale
    go_idle(4, 0, 0);
    start();
    run("p4", 40, 4, 2, 9, 0);

    // Mid-frame config change is ignored until the next idle cycle
    go_idle(8, 0, 0);
    start();
    run("chg_a", 24, 8, 4, 9, 0);
    prescale = 6'd16; PAR_EN = 1'b1; #1;
    run("chg_b", 64, 8, 4, 9, 24);
    go_idle(16, 1, 0);
    start();
    run("chg_c", 176, 16, 8, 10, 0);

    // Drop enable at bit 4 edge 6: next cycle fully cleared
    go_idle(8, 0, 0);
    start();
    run("drop_a", 38, 8, 4, 9, 0);
    cnt_en = 1'b0; #1;
    check_all("drop_at", 38, 6, 4, 0, 0, 0, 0, 0);
    tick();
    check_all("drop_nxt", 39, 0, 0, 0, 0, 0, 0, 0);

    // Enable falls right after a bit_done cycle: pulse fired, then clear
    start();
    run("drop_bd", 8, 8, 4, 9, 0);
    cnt_en = 1'b0; #1;
    check_all("drop_bd_off", 8, 0, 1, 0, 0, 0, 0, 0);
    tick();
    check_all("drop_bd_clr", 9, 0, 0, 0, 0, 0, 0, 0);

    // prescale below 4 locks the counters
    go_idle(3, 0, 0);
    start();
    for (int k = 0; k < 50; k++) begin
      check_all("cfg_err", k, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    cnt_en = 1'b0; prescale = 6'd8; #1;
    chk("cfg_err_hold", 0, 32'(cfg_err), 1);
    tick();
    chk("cfg_err_clr", 0, 32'(cfg_err), 0);
    start();
    run("resume", 52, 8, 4, 9, 0);

    // Reset at bit 6 while enabled; shadow returns to 8 despite prescale=16
    RST = 1'b0; prescale = 6'd16; #1;
    tick();
    check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1; #1;
    run("post_rst", 16, 8, 4, 9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
